// File: rtl/bytecode_prefetch_if.sv
// Fetch-stage bundle: code-memory read port, decode valid/ready handshake and redirect control.
interface bytecode_prefetch_if #(
  parameter int ADDR_W = 12,
  parameter int LVL_W  = 3
);
  logic              fetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] pc;
  logic              valid;
  logic              ready;
  logic [LVL_W-1:0]  level;

  modport master (
    input  fetch_en, redirect, redirect_pc, mem_rdata, ready,
    output mem_en, mem_addr, instr, pc, valid, level
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, mem_rdata, ready,
    input  mem_en, mem_addr, instr, pc, valid, level
  );
endinterface

// File: rtl/bytecode_prefetch.sv
// Prefetching bytecode front end: sequential code-memory reads feed a DEPTH-entry
// {byte, pc} queue presented to decode; redirect flushes and restarts fetch.
module bytecode_prefetch #(
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  bytecode_prefetch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = LVL_W + 1;

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic              inflight_r;
  logic [7:0]        byte_q_r [DEPTH];
  logic [ADDR_W-1:0] pc_q_r   [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [LVL_W-1:0]  count_r;

  logic credit_s;
  logic issue_s;
  logic push_s;
  logic pop_s;

  // Credit counts the in-flight byte so a returning response always has a free slot.
  always_comb begin
    credit_s = ({1'b0, count_r} + {{LVL_W{1'b0}}, inflight_r}) < CNT_W'(DEPTH);
    issue_s  = bus.fetch_en & ~bus.redirect & credit_s & ~rst;
    push_s   = inflight_r & ~bus.redirect;
    pop_s    = (count_r != {LVL_W{1'b0}}) & bus.ready;
  end

  // Fetch pointer, in-flight tracking, queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_pc_r <= {ADDR_W{1'b0}};
      inflight_r    <= 1'b0;
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {LVL_W{1'b0}};
    end else if (bus.redirect) begin
      fetch_pc_r <= bus.redirect_pc;
      inflight_r <= 1'b0;
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {LVL_W{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + ADDR_W'(1);
      end
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; returning byte is tagged with the address it was issued at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        byte_q_r[i] <= 8'h00;
        pc_q_r[i]   <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      byte_q_r[tail_r] <= bus.mem_rdata;
      pc_q_r[tail_r]   <= inflight_pc_r;
    end
  end

  // Head entry is read straight out of storage.
  always_comb begin
    bus.mem_en   = issue_s;
    bus.mem_addr = fetch_pc_r;
    bus.instr    = byte_q_r[head_r];
    bus.pc       = pc_q_r[head_r];
    bus.valid    = (count_r != {LVL_W{1'b0}});
    bus.level    = count_r;
  end
endmodule

// File: doc/bytecode_prefetch.md
# bytecode_prefetch

Parametrised bytecode fetch stage for the Java processor core: it replaces the single-byte fetch unit with a prefetching front end. It issues sequential byte reads to synchronous code memory, buffers returned bytecodes with their PCs in a DEPTH-entry queue, and presents them to decode over a valid/ready handshake. A redirect input (branch, invoke or return target) flushes the queue and restarts fetch at a new PC.

## Interface
- ADDR_W, 12, code address / PC width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset
- LVL_W, $clog2(DEPTH+1), width of level output

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_en  in  1  permits new memory requests when high
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- mem_en  out  1  read request to code memory
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  8  read data, valid exactly one cycle after mem_en
- instr  out  8  bytecode at queue head
- pc  out  ADDR_W  address of instr
- valid  out  1  head entry present
- ready  in  1  decode accepts head this cycle
- level  out  LVL_W  number of queued entries, 0..DEPTH

## Operation
- State: fetch_pc (ADDR_W), inflight flag plus its address, queue (DEPTH × {8-bit byte, ADDR_W pc}), head/tail pointers, count.
- Reset: fetch_pc = RESET_PC; queue empty; inflight = 0; mem_en = 0, mem_addr = RESET_PC, valid = 0, instr = 0, pc = 0, level = 0.
- Issue (combinational mem_en): mem_en = fetch_en & !redirect & (count + inflight < DEPTH). On issue, mem_addr = fetch_pc; fetch_pc increments by 1 modulo 2^ADDR_W (0xFFF → 0x000 at ADDR_W=12). inflight is set for the next cycle and records the issued address.
- Return: in any cycle with inflight = 1 and no redirect, mem_rdata and the recorded address are pushed at the queue tail. The credit rule guarantees no overflow; no full check is needed on the push.
- Pop: when valid & ready, the head advances. Push and pop may occur in the same cycle; count is then unchanged.
- Outputs: valid = (count != 0); instr/pc driven from the head entry (registered storage, combinational read); level = count.
- Redirect (highest priority): count ← 0; pointers ← 0; inflight ← 0 (the returning byte is dropped); fetch_pc ← redirect_pc; mem_en = 0 in the redirect cycle. A pop in the redirect cycle is treated as accepted by decode, but the flush still empties the queue.
- fetch_en low: no new issues; the in-flight byte still lands; queued entries remain poppable.

## Timing
- Cycle 0 is the first edge after rst falls. mem_en = 1 with addr RESET_PC in cycle 0; data arrives in cycle 1; valid = 1 with pc = RESET_PC in cycle 2.
- Steady state with ready held high: one bytecode per cycle, count oscillates at 1, no bubbles.
- Redirect asserted in cycle t: valid = 0 in t+1; mem_en with redirect_pc in t+1; valid with pc = redirect_pc in t+3.
- With ready low, the queue fills to DEPTH and mem_en deasserts. When ready rises, issue resumes the same cycle count + inflight < DEPTH.
- rst asserted mid-operation clears all state immediately (asynchronous); any outstanding memory response is ignored.

## Test plan
- Reset release, ready = 1, memory byte[a] = a & 0xFF: pops 0x00,0x01,0x02… with pc 0,1,2… starting cycle 2, one per cycle, level ≤ 1.
- ready = 0 for 10 cycles: level reaches 4, mem_en low after 4 issues; ready = 1: bytes resume in order with no loss or duplication.
- Redirect to 0x100 while 3 entries are queued and one is in flight: next valid byte has pc 0x100 three cycles later; no pre-redirect byte appears after the flush.
- RESET_PC = 0xFFE: fetched pcs are 0xFFE, 0xFFF, 0x000, 0x001.
- fetch_en dropped after 2 issues with ready = 0: level settles at 2 (in-flight byte included); raising fetch_en resumes at pc 2.
- rst pulsed mid-stream with the queue full: valid, level and mem_en are 0 immediately; restart begins from RESET_PC.
